mems_scan_sequencer: RTL

//  Parametrised MEMS scan sequencer driving a quad/octal 24-bit SPI DAC (AD56x4-style word) through the SPI master.

---
 rtl/mems_scan_pkg.sv | 23 ++
 rtl/mems_axis_ramp.sv | 67 ++++++
 rtl/mems_scan_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mems_scan_pkg.sv
// Shared definitions for the MEMS scan sequencer: DAC commands, FSM encoding, word formatter.
package mems_scan_pkg;

  localparam logic [2:0] CMD_WR_IN      = 3'b000;
  localparam logic [2:0] CMD_WR_UPD_ALL = 3'b010;
  localparam logic [2:0] CMD_SW_RST     = 3'b101;
  localparam logic [2:0] CMD_LDAC       = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_RST,
    ST_INIT_LDAC,
    ST_PT_WAIT,
    ST_PT_WR
  } state_t;

  // code16 arrives already left-aligned
  function automatic logic [23:0] fmt_word(input logic [2:0] cmd, input logic [2:0] addr,
                                           input logic [15:0] code16);
    return {2'b00, cmd, addr, code16};
  endfunction

endpackage

// File: rtl/mems_axis_ramp.sv
// One scan axis: fast axis does sawtooth/triangle with variable step, slow axes count by 1 on carry.
module mems_axis_ramp #(
  parameter int CODE_W     = 8,
  parameter int DOWN_LIMIT = 34,
  parameter int UP_LIMIT   = 154,
  parameter bit FAST       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              carry_in,
  input  logic              tri_en,
  input  logic [CODE_W-1:0] step,
  output logic [CODE_W-1:0] pos,
  output logic              carry_out
);
  localparam logic [CODE_W:0] DN = (CODE_W+1)'(DOWN_LIMIT);
  localparam logic [CODE_W:0] UP = (CODE_W+1)'(UP_LIMIT);

  logic [CODE_W-1:0] pos_q, pos_d, stp;
  logic              dir_up_q, dir_up_d, tri_act;
  logic [CODE_W:0]   sum, lo;

  assign stp     = FAST ? step : CODE_W'(1);
  assign tri_act = FAST && tri_en;
  // one extra bit keeps pos+step and DOWN_LIMIT+step from wrapping
  assign sum     = {1'b0, pos_q} + {1'b0, stp};
  assign lo      = DN + {1'b0, stp};

  always_comb begin
    pos_d     = pos_q;
    dir_up_d  = dir_up_q;
    carry_out = 1'b0;
    if (advance && carry_in) begin
      if (tri_act && !dir_up_q) begin
        if ({1'b0, pos_q} < lo) begin
          pos_d     = DN[CODE_W-1:0];
          dir_up_d  = 1'b1;
          carry_out = 1'b1;
        end else begin
          pos_d = pos_q - stp;
        end
      end else if (sum > UP) begin
        carry_out = 1'b1;
        pos_d     = tri_act ? UP[CODE_W-1:0] : DN[CODE_W-1:0];
        dir_up_d  = !tri_act;
      end else begin
        // sawtooth always runs upward, which also clears a stale down direction
        pos_d    = sum[CODE_W-1:0];
        dir_up_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q    <= DN[CODE_W-1:0];
      dir_up_q <= 1'b1;
    end else begin
      pos_q    <= pos_d;
      dir_up_q <= dir_up_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/mems_scan_sequencer.sv
// MEMS scan sequencer: DAC init, then per point 2*N_AXES differential writes through the SPI master.
module mems_scan_sequencer
  import mems_scan_pkg::*;
#(
  parameter int N_AXES     = 2,
  parameter int CODE_W     = 8,
  parameter int DOWN_LIMIT = 34,
  parameter int UP_LIMIT   = 154
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_req,
  input  logic              stop_req,
  input  logic              pause,
  input  logic              tri_mode,
  input  logic [CODE_W-1:0] step,
  input  logic              spi_busy,
  output logic              spi_start,
  output logic [23:0]       spi_word,
  input  logic              line_ack,
  input  logic              frame_ack,
  output logic              new_line,
  output logic              new_frame,
  output logic              running
);
  localparam int NCH = 2 * N_AXES;

  state_t state, state_n;
  logic [2:0]                    ch_q;
  logic                          launch, launch_ok, advance, last_ch;
  logic                          spi_start_q, new_line_q, new_frame_q;
  logic [23:0]                   spi_word_q, word_n;
  logic [CODE_W-1:0]             step_eff, sel_pos, ch_code;
  logic [15:0]                   code16;
  logic [N_AXES:0]               cin;
  logic [N_AXES-1:0][CODE_W-1:0] pos;

  assign step_eff  = (step == '0) ? CODE_W'(1) : step;
  // spi_start_q covers the cycle before the master raises busy
  assign launch_ok = !spi_busy && !spi_start_q;
  assign last_ch   = (ch_q == 3'(NCH - 1));
  assign cin[0]    = 1'b1;

  for (genvar k = 0; k < N_AXES; k++) begin : g_axis
    mems_axis_ramp #(
      .CODE_W(CODE_W), .DOWN_LIMIT(DOWN_LIMIT), .UP_LIMIT(UP_LIMIT), .FAST(k == 0)
    ) u_axis (
      .clk(clk), .rst(rst), .advance(advance), .carry_in(cin[k]), .tri_en(tri_mode),
      .step(step_eff), .pos(pos[k]), .carry_out(cin[k+1])
    );
  end

  always_comb begin
    sel_pos = pos[0];
    for (int k = 0; k < N_AXES; k++)
      if (ch_q[2:1] == 2'(k)) sel_pos = pos[k];
  end

  // odd channel is the mirrored half of the differential pair
  assign ch_code = ch_q[0] ? CODE_W'(UP_LIMIT + DOWN_LIMIT) - sel_pos : sel_pos;
  assign code16  = 16'(ch_code) << (16 - CODE_W);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:      if (start_req) state_n = ST_INIT_RST;
      ST_INIT_RST:  if (launch_ok) state_n = ST_INIT_LDAC;
      ST_INIT_LDAC: if (launch_ok) state_n = ST_PT_WAIT;
      ST_PT_WAIT:   if (stop_req) state_n = ST_IDLE;
                    else if (!pause) state_n = ST_PT_WR;
      ST_PT_WR:     if (launch_ok && last_ch) state_n = ST_PT_WAIT;
      default:      state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    launch  = 1'b0;
    advance = 1'b0;
    word_n  = spi_word_q;
    case (state)
      ST_INIT_RST: begin
        launch = launch_ok;
        word_n = fmt_word(CMD_SW_RST, 3'd0, 16'h0001);
      end
      ST_INIT_LDAC: begin
        launch = launch_ok;
        word_n = fmt_word(CMD_LDAC, 3'd0, 16'h0000);
      end
      ST_PT_WAIT: advance = !stop_req && !pause;
      ST_PT_WR: begin
        launch = launch_ok;
        word_n = fmt_word(last_ch ? CMD_WR_UPD_ALL : CMD_WR_IN, ch_q, code16);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spi_start_q <= 1'b0;
      spi_word_q  <= '0;
      ch_q        <= '0;
      new_line_q  <= 1'b0;
      new_frame_q <= 1'b0;
    end else begin
      spi_start_q <= launch;
      if (launch) spi_word_q <= word_n;
      if (advance) ch_q <= '0;
      else if (state == ST_PT_WR && launch) ch_q <= ch_q + 3'd1;
      // set beats ack; a frame end is never also reported as a line
      new_frame_q <= (advance && cin[N_AXES]) || (new_frame_q && !frame_ack);
      new_line_q  <= (advance && cin[1] && !cin[N_AXES]) || (new_line_q && !line_ack);
    end
  end

  assign spi_start = spi_start_q;
  assign spi_word  = spi_word_q;
  assign new_line  = new_line_q;
  assign new_frame = new_frame_q;
  assign running   = (state != ST_IDLE);

endmodule
